// File: rtl/mac_pkg.sv
// Shared definitions for the product accumulator: state encoding,
// fixed product width, default accumulator/counter widths and term limit.
package mac_pkg;

    // Width of the product delivered by the 32x32 multiplier.
    localparam int PROD_WIDTH = 64;

    // Default accumulator width: 8 guard bits above the product.
    localparam int ACC_W_DEF  = 72;

    // Default term-counter width.
    localparam int CNT_W_DEF  = 8;

    // Largest number of terms one result may hold for a given counter width.
    localparam int CNT_MAX_DEF = (1 << CNT_W_DEF) - 1;

    // Accumulator FSM states.
    // ST_ACCUM takes beats (in_ready=1).
    // ST_HOLD presents a finished result (out_valid=1).
    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } mac_state_t;

    // Maximum terms per result for a counter of cnt_w bits.
    function automatic int cnt_max(input int cnt_w);
        return (1 << cnt_w) - 1;
    endfunction

endpackage

// File: rtl/mac_acc_adder.sv
// Combinational W-bit ripple-carry adder with carry out.
// Same bit-serial carry chain as the adder32/adder48 blocks.
module mac_acc_adder #(
    parameter int W = 72
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum,
    output logic         carry
);

    // Ripple the carry from bit 0 upward; carry is the bit leaving the MSB.
    always_comb begin
        logic c;
        c     = 1'b0;
        sum   = '0;
        for (int i = 0; i < W; i++) begin
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        carry = c;
    end

endmodule

// File: rtl/vedic_mac_accumulator.sv
// Accumulates unsigned multiplier products into a wide running sum and
// hands one result per dot-product to the writeback path.
//
// Handshake: a transfer happens on a rising edge where valid and ready
// are both high. The input side accepts a beat only when in_valid &
// in_ready. The output side retires the result only when out_valid &
// out_ready. While out_valid is high and out_ready is low, every out_*
// value stays stable. A beat offered while the block is not ready stays
// with the upstream stage and is never dropped.
module vedic_mac_accumulator
    import mac_pkg::*;
#(
    parameter int PROD_W = PROD_WIDTH,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_prod,
    input  logic              in_last,
    input  logic              acc_clr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_acc,
    output logic [CNT_W-1:0]  out_cnt,
    output logic              out_ovf,
    output logic              out_forced
);

    // A sum closes on its own once it already holds this many terms
    // (before the current beat), so the result never exceeds cnt_max terms.
    localparam logic [CNT_W-1:0] CNT_CLOSE = CNT_W'(cnt_max(CNT_W) - 1);

    mac_state_t        state;
    logic [ACC_W-1:0]  acc;
    logic [CNT_W-1:0]  cnt;
    logic              ovf;

    logic              beat;
    logic              close;
    logic [ACC_W-1:0]  acc_base;
    logic [CNT_W-1:0]  cnt_base;
    logic              ovf_base;
    logic [CNT_W-1:0]  cnt_next;
    logic [ACC_W-1:0]  prod_ext;
    logic [ACC_W-1:0]  acc_sum;
    logic              acc_carry;

    // Both handshake flags come straight from the state register.
    assign in_ready  = (state == ST_ACCUM);
    assign out_valid = (state == ST_HOLD);

    // Products are unsigned, so widen with zeros only.
    assign prod_ext  = ACC_W'(in_prod);

    // Running-sum view for this cycle.
    // A clear on the same cycle as a beat makes that beat the first term.
    always_comb begin
        beat     = in_valid & in_ready;
        acc_base = acc_clr ? '0 : acc;
        cnt_base = acc_clr ? '0 : cnt;
        ovf_base = acc_clr ? 1'b0 : ovf;
        cnt_next = cnt_base + 1'b1;
        close    = beat & (in_last | (cnt_base == CNT_CLOSE));
    end

    mac_acc_adder #(
        .W (ACC_W)
    ) u_adder (
        .a     (acc_base),
        .b     (prod_ext),
        .sum   (acc_sum),
        .carry (acc_carry)
    );

    // FSM, running sum/count/sticky overflow, and the output register bank.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_ACCUM;
            acc        <= '0;
            cnt        <= '0;
            ovf        <= 1'b0;
            out_acc    <= '0;
            out_cnt    <= '0;
            out_ovf    <= 1'b0;
            out_forced <= 1'b0;
        end else begin
            case (state)
                ST_ACCUM: begin
                    if (close) begin
                        out_acc    <= acc_sum;
                        out_cnt    <= cnt_next;
                        out_ovf    <= ovf_base | acc_carry;
                        out_forced <= ~in_last;
                        acc        <= '0;
                        cnt        <= '0;
                        ovf        <= 1'b0;
                        state      <= ST_HOLD;
                    end else if (beat) begin
                        acc        <= acc_sum;
                        cnt        <= cnt_next;
                        ovf        <= ovf_base | acc_carry;
                    end else if (acc_clr) begin
                        acc        <= '0;
                        cnt        <= '0;
                        ovf        <= 1'b0;
                    end
                end
                ST_HOLD: begin
                    // The running state is already zero here, so acc_clr has nothing to do.
                    if (out_ready) begin
                        state <= ST_ACCUM;
                    end
                end
                default: begin
                    state <= ST_ACCUM;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vedic_mac_accumulator.sv
// Directed bench for vedic_mac_accumulator.
// Three instances (default widths, ACC_W=64, CNT_W=3) share one stimulus bus.
// Each scenario resets all of them and checks the instance it targets.
module tb_vedic_mac_accumulator;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [63:0] in_prod = '0;
    logic        in_last = 1'b0;
    logic        acc_clr = 1'b0;
    logic        out_ready = 1'b0;

    // default instance outputs
    logic        in_ready, out_valid, out_ovf, out_forced;
    logic [71:0] out_acc;
    logic [7:0]  out_cnt;
    // ACC_W=64 instance outputs
    logic        b_in_ready, b_out_valid, b_out_ovf, b_out_forced;
    logic [63:0] b_out_acc;
    logic [7:0]  b_out_cnt;
    // CNT_W=3 instance outputs
    logic        c_in_ready, c_out_valid, c_out_ovf, c_out_forced;
    logic [71:0] c_out_acc;
    logic [2:0]  c_out_cnt;

    int n_vec = 0;
    int n_err = 0;

    // clock / reset block
    always #5 clk = ~clk;

    vedic_mac_accumulator dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_prod(in_prod), .in_last(in_last), .acc_clr(acc_clr),
        .out_valid(out_valid), .out_ready(out_ready), .out_acc(out_acc),
        .out_cnt(out_cnt), .out_ovf(out_ovf), .out_forced(out_forced)
    );

    vedic_mac_accumulator #(.ACC_W(64)) dut_w64 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_prod(in_prod), .in_last(in_last), .acc_clr(acc_clr),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_acc(b_out_acc),
        .out_cnt(b_out_cnt), .out_ovf(b_out_ovf), .out_forced(b_out_forced)
    );

    vedic_mac_accumulator #(.CNT_W(3)) dut_c3 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(c_in_ready),
        .in_prod(in_prod), .in_last(in_last), .acc_clr(acc_clr),
        .out_valid(c_out_valid), .out_ready(out_ready), .out_acc(c_out_acc),
        .out_cnt(c_out_cnt), .out_ovf(c_out_ovf), .out_forced(c_out_forced)
    );

    // driver tasks: advance one edge, then settle 1ns past it before sampling
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; acc_clr = 1'b0; out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic send_beat(input logic [63:0] prod, input logic last);
        in_valid = 1'b1; in_prod = prod; in_last = last;
        tick();
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        n_vec++; if (out_acc !== 72'd0) begin n_err++; $display("FAIL reset_out_acc got %0d want 0", out_acc); end
        n_vec++; if (out_cnt !== 8'd0) begin n_err++; $display("FAIL reset_out_cnt got %0d want 0", out_cnt); end
        n_vec++; if ({out_ovf, out_forced} !== 2'b00) begin n_err++; $display("FAIL reset_flags got %b want 00", {out_ovf, out_forced}); end
    endtask

    task automatic test_basic_sum();
        do_reset();
        send_beat(64'd3, 1'b0);
        send_beat(64'd5, 1'b0);
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL basic_early_valid got %b want 0", out_valid); end
        send_beat(64'd7, 1'b1);
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL basic_latency got %b want 1", out_valid); end
        n_vec++; if (out_acc !== 72'd15) begin n_err++; $display("FAIL basic_acc got %0d want 15", out_acc); end
        n_vec++; if (out_cnt !== 8'd3) begin n_err++; $display("FAIL basic_cnt got %0d want 3", out_cnt); end
        n_vec++; if ({out_ovf, out_forced} !== 2'b00) begin n_err++; $display("FAIL basic_flags got %b want 00", {out_ovf, out_forced}); end
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL basic_hold_ready got %b want 0", in_ready); end
        release_result();
        n_vec++; if ({out_valid, in_ready} !== 2'b01) begin n_err++; $display("FAIL basic_release got %b want 01", {out_valid, in_ready}); end
    endtask

    task automatic test_backpressure();
        do_reset();
        send_beat(64'd1, 1'b0);
        send_beat(64'd2, 1'b1);
        // offer a beat while the result is held; it must wait
        in_valid = 1'b1; in_prod = 64'd100; in_last = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_vec++; if ({out_valid, in_ready} !== 2'b10) begin n_err++; $display("FAIL bp_hold_flags cycle %0d got %b want 10", i, {out_valid, in_ready}); end
            n_vec++; if (out_acc !== 72'd3 || out_cnt !== 8'd2) begin n_err++; $display("FAIL bp_hold_data cycle %0d got %0d/%0d want 3/2", i, out_acc, out_cnt); end
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_vec++; if ({out_valid, in_ready} !== 2'b01) begin n_err++; $display("FAIL bp_release got %b want 01", {out_valid, in_ready}); end
        tick();
        in_valid = 1'b0; in_last = 1'b0;
        n_vec++; if (out_valid !== 1'b1 || out_acc !== 72'd100 || out_cnt !== 8'd1) begin
            n_err++; $display("FAIL bp_held_beat got v=%b %0d/%0d want v=1 100/1", out_valid, out_acc, out_cnt);
        end
        release_result();
    endtask

    task automatic test_overflow();
        do_reset();
        send_beat(64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        send_beat(64'd2, 1'b1);
        n_vec++; if (b_out_acc !== 64'd1 || b_out_ovf !== 1'b1) begin n_err++; $display("FAIL ovf64_wrap got %0d ovf=%b want 1 ovf=1", b_out_acc, b_out_ovf); end
        n_vec++; if (b_out_cnt !== 8'd2 || b_out_forced !== 1'b0) begin n_err++; $display("FAIL ovf64_cnt got %0d forced=%b want 2 forced=0", b_out_cnt, b_out_forced); end
        // the 72-bit accumulator keeps the carry in its guard bits
        n_vec++; if (out_acc !== 72'h01_0000_0000_0000_0001 || out_ovf !== 1'b0) begin n_err++; $display("FAIL ovf72_guard got %h ovf=%b want 010000000000000001 ovf=0", out_acc, out_ovf); end
        release_result();
        send_beat(64'd1, 1'b0);
        send_beat(64'd3, 1'b1);
        n_vec++; if (b_out_acc !== 64'd4 || b_out_ovf !== 1'b0) begin n_err++; $display("FAIL ovf64_sticky_clear got %0d ovf=%b want 4 ovf=0", b_out_acc, b_out_ovf); end
        release_result();
    endtask

    task automatic test_count_limit();
        do_reset();
        for (int i = 0; i < 6; i++) send_beat(64'd1, 1'b0);
        n_vec++; if (c_out_valid !== 1'b0) begin n_err++; $display("FAIL lim3_early got %b want 0", c_out_valid); end
        send_beat(64'd1, 1'b0);
        n_vec++; if (c_out_valid !== 1'b1 || c_out_acc !== 72'd7 || c_out_cnt !== 3'd7) begin
            n_err++; $display("FAIL lim3_result got v=%b %0d/%0d want v=1 7/7", c_out_valid, c_out_acc, c_out_cnt);
        end
        n_vec++; if (c_out_forced !== 1'b1) begin n_err++; $display("FAIL lim3_forced got %b want 1", c_out_forced); end
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL lim8_not_closed got %b want 0", out_valid); end
        release_result();
        send_beat(64'd5, 1'b1);
        n_vec++; if (c_out_acc !== 72'd5 || c_out_cnt !== 3'd1 || c_out_forced !== 1'b0) begin
            n_err++; $display("FAIL lim3_next got %0d/%0d forced=%b want 5/1 forced=0", c_out_acc, c_out_cnt, c_out_forced);
        end
        n_vec++; if (out_acc !== 72'd12 || out_cnt !== 8'd8) begin n_err++; $display("FAIL lim8_running got %0d/%0d want 12/8", out_acc, out_cnt); end
        release_result();
        // default counter: 255 terms close the sum without in_last
        do_reset();
        for (int i = 0; i < 254; i++) send_beat(64'd2, 1'b0);
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL lim8_early got %b want 0", out_valid); end
        send_beat(64'd2, 1'b0);
        n_vec++; if (out_valid !== 1'b1 || out_acc !== 72'd510 || out_cnt !== 8'd255 || out_forced !== 1'b1) begin
            n_err++; $display("FAIL lim8_result got v=%b %0d/%0d forced=%b want v=1 510/255 forced=1", out_valid, out_acc, out_cnt, out_forced);
        end
        release_result();
    endtask

    task automatic test_clear();
        do_reset();
        send_beat(64'd10, 1'b0);
        send_beat(64'd20, 1'b0);
        acc_clr = 1'b1;
        send_beat(64'd4, 1'b1);
        acc_clr = 1'b0;
        n_vec++; if (out_acc !== 72'd4 || out_cnt !== 8'd1 || out_ovf !== 1'b0) begin
            n_err++; $display("FAIL clr_with_beat got %0d/%0d ovf=%b want 4/1 ovf=0", out_acc, out_cnt, out_ovf);
        end
        // clear is ignored while a result is held
        acc_clr = 1'b1;
        tick();
        acc_clr = 1'b0;
        n_vec++; if (out_valid !== 1'b1 || out_acc !== 72'd4 || out_cnt !== 8'd1) begin
            n_err++; $display("FAIL clr_in_hold got v=%b %0d/%0d want v=1 4/1", out_valid, out_acc, out_cnt);
        end
        release_result();
        // clear alone, then a fresh sum
        send_beat(64'd50, 1'b0);
        acc_clr = 1'b1;
        tick();
        acc_clr = 1'b0;
        in_last = 1'b1;
        tick();
        in_last = 1'b0;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL last_without_valid got %b want 0", out_valid); end
        send_beat(64'd6, 1'b1);
        n_vec++; if (out_acc !== 72'd6 || out_cnt !== 8'd1) begin n_err++; $display("FAIL clr_alone got %0d/%0d want 6/1", out_acc, out_cnt); end
        release_result();
    endtask

    task automatic test_reset_in_hold();
        do_reset();
        send_beat(64'd8, 1'b0);
        send_beat(64'd9, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_vec++; if ({out_valid, in_ready} !== 2'b01) begin n_err++; $display("FAIL rst_hold_flags got %b want 01", {out_valid, in_ready}); end
        send_beat(64'd9, 1'b1);
        n_vec++; if (out_acc !== 72'd9 || out_cnt !== 8'd1) begin n_err++; $display("FAIL rst_hold_acc got %0d/%0d want 9/1", out_acc, out_cnt); end
        release_result();
        // reset in the middle of a sum discards the partial
        send_beat(64'd40, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        send_beat(64'd2, 1'b1);
        n_vec++; if (out_acc !== 72'd2 || out_cnt !== 8'd1) begin n_err++; $display("FAIL rst_mid_sum got %0d/%0d want 2/1", out_acc, out_cnt); end
        release_result();
    endtask

    task automatic test_back_to_back();
        logic [71:0] exp_q[$];
        logic [71:0] exp;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            logic [71:0] s;
            s = '0;
            for (int j = 0; j < 3; j++) begin
                logic [63:0] p;
                p = 64'($urandom_range(1000, 1)) << (20 * j);
                s = s + 72'(p);
                send_beat(p, j == 2);
            end
            exp_q.push_back(s);
            exp = exp_q.pop_front();
            n_vec++; if (out_valid !== 1'b1 || out_acc !== exp || out_cnt !== 8'd3) begin
                n_err++; $display("FAIL b2b_sum %0d got v=%b %0d/%0d want v=1 %0d/3", k, out_valid, out_acc, out_cnt, exp);
            end
            release_result();
        end
    endtask

    initial begin
        test_reset();
        test_basic_sum();
        test_backpressure();
        test_overflow();
        test_count_limit();
        test_clear();
        test_reset_in_hold();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
